grid_load_sequencer: RTL and testbench

Upstream sequencer for the cell-grid system memory. It accepts the initial grid as parallel words over a valid/ready handshake and serializes them MSB-first onto the memory's serial input with load mode asserted. It then drives run mode for a requested number of generations and reports completion. It owns every `load_mode`/`run_mode` transition, so the memory never sees both asserted.

---
 rtl/grid_load_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_grid_load_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_load_sequencer.sv
// grid_load_sequencer
// Loads an initial cell grid into the system memory over its serial port
// (MSB first, load_mode high), then drives run_mode for a requested number
// of generations and flags completion. This block is the only source of
// load_mode/run_mode, so the two are never asserted together.
//
// Optional feature macro: GRID_LOAD_SEQUENCER_PAUSE_EN
//   defined   - pause=1 in RUN suppresses run_mode and freezes stepping
//   undefined - pause is ignored
module grid_load_sequencer #(
    parameter int DATA_SIZE  = 25,
    parameter int WORD_WIDTH = 8,
    parameter int GEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  begin_load,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic                  start_run,
    input  logic [GEN_WIDTH-1:0]  gen_count,
    input  logic                  pause,
    output logic                  serial_out,
    output logic                  load_mode,
    output logic                  run_mode,
    output logic                  loaded,
    output logic                  done,
    output logic [GEN_WIDTH-1:0]  gens_done
);

    localparam int BCW = $clog2(DATA_SIZE + 1);
    localparam int WCW = $clog2(WORD_WIDTH + 1);
    localparam logic [BCW-1:0] LP_LAST_BIT  = BCW'(DATA_SIZE - 1);
    localparam logic [WCW-1:0] LP_LAST_WBIT = WCW'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_WORD,
        S_SHIFT,
        S_LOADED,
        S_RUN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [WORD_WIDTH-1:0] r_shreg;
    logic [WORD_WIDTH-1:0] w_shreg_next;
    logic [BCW-1:0]        r_bit_cnt;
    logic [WCW-1:0]        r_word_bit;
    logic [GEN_WIDTH-1:0]  r_gen_target;
    logic [GEN_WIDTH-1:0]  r_gens_done;
    logic [GEN_WIDTH-1:0]  w_gens_inc;

    logic                  r_word_ready;
    logic                  r_serial_out;
    logic                  r_load_mode;
    logic                  r_run_mode;
    logic                  r_loaded;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_clear;
    logic                  w_step;
    logic                  w_latch_gen;
    logic                  w_pause_act;
    logic                  w_hold;

`ifdef GRID_LOAD_SEQUENCER_PAUSE_EN
    assign w_pause_act = pause;
`else
    // pause is ignored in this build; the AND keeps the port referenced
    assign w_pause_act = pause & 1'b0;
`endif

    // A paused RUN cycle: no run_mode pulse in the following cycle
    assign w_hold     = (r_state == S_RUN) && w_pause_act;
    assign w_gens_inc = r_gens_done + GEN_WIDTH'(1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and the strobes that steer the counters
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_clear      = 1'b0;
        w_step       = 1'b0;
        w_latch_gen  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (begin_load) begin
                    w_next_state = S_WAIT_WORD;
                    w_clear      = 1'b1;
                end
            end
            S_WAIT_WORD: begin
                if (word_valid && r_word_ready) begin
                    w_next_state = S_SHIFT;
                    w_accept     = 1'b1;
                end
            end
            S_SHIFT: begin
                // Grid-full check wins: leftover bits of the last word are dropped
                if (r_bit_cnt == LP_LAST_BIT) begin
                    w_next_state = S_LOADED;
                end else if (r_word_bit == LP_LAST_WBIT) begin
                    w_next_state = S_WAIT_WORD;
                end
            end
            S_LOADED: begin
                if (start_run) begin
                    if (gen_count != '0) begin
                        w_next_state = S_RUN;
                        w_latch_gen  = 1'b1;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end else if (begin_load) begin
                    w_next_state = S_WAIT_WORD;
                    w_clear      = 1'b1;
                end
            end
            S_RUN: begin
                // A generation completes at the end of every run_mode cycle
                if (r_run_mode) begin
                    w_step = 1'b1;
                    if (w_gens_inc == r_gen_target) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (begin_load) begin
                    w_next_state = S_WAIT_WORD;
                    w_clear      = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Shift register: load on accept, shift left while serialising
    always_comb begin
        w_shreg_next = r_shreg;
        if (w_accept) begin
            w_shreg_next = word_in;
        end else if (r_state == S_SHIFT) begin
            w_shreg_next = r_shreg << 1;
        end
    end

    // Shift data holds no control meaning, so it is not reset
    always_ff @(posedge clk) begin
        r_shreg <= w_shreg_next;
    end

    // Bit, word-bit and generation counters plus the latched run length
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt    <= '0;
            r_word_bit   <= '0;
            r_gens_done  <= '0;
            r_gen_target <= '0;
        end else begin
            if (w_clear) begin
                r_bit_cnt <= '0;
            end else if (r_state == S_SHIFT) begin
                r_bit_cnt <= r_bit_cnt + BCW'(1);
            end

            if (w_accept) begin
                r_word_bit <= '0;
            end else if (r_state == S_SHIFT) begin
                r_word_bit <= r_word_bit + WCW'(1);
            end

            if (w_clear) begin
                r_gens_done <= '0;
            end else if (w_step) begin
                r_gens_done <= w_gens_inc;
            end

            if (w_latch_gen) begin
                r_gen_target <= gen_count;
            end
        end
    end

    // Registered outputs, decoded from the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word_ready <= 1'b0;
            r_serial_out <= 1'b0;
            r_load_mode  <= 1'b0;
            r_run_mode   <= 1'b0;
            r_loaded     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_word_ready <= (w_next_state == S_WAIT_WORD);
            r_load_mode  <= (w_next_state == S_SHIFT);
            r_serial_out <= (w_next_state == S_SHIFT) ? w_shreg_next[WORD_WIDTH-1] : 1'b0;
            r_run_mode   <= (w_next_state == S_RUN) && !w_hold;
            r_loaded     <= (w_next_state == S_LOADED);
            r_done       <= (w_next_state == S_DONE);
        end
    end

    assign word_ready = r_word_ready;
    assign serial_out = r_serial_out;
    assign load_mode  = r_load_mode;
    assign run_mode   = r_run_mode;
    assign loaded     = r_loaded;
    assign done       = r_done;
    assign gens_done  = r_gens_done;

endmodule

// File: tb/tb_grid_load_sequencer.sv
// Directed bench for grid_load_sequencer with DATA_SIZE=5, WORD_WIDTH=4.
// A small shift-register stands in for the system memory's serial input.
module tb_grid_load_sequencer;

    localparam int DS = 5;
    localparam int WW = 4;
    localparam int GW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          begin_load = 1'b0;
    logic [WW-1:0] word_in = '0;
    logic          word_valid = 1'b0;
    logic          word_ready;
    logic          start_run = 1'b0;
    logic [GW-1:0] gen_count = '0;
    logic          pause = 1'b0;
    logic          serial_out;
    logic          load_mode;
    logic          run_mode;
    logic          loaded;
    logic          done;
    logic [GW-1:0] gens_done;

    int errors = 0;
    int checks = 0;

    // Memory stand-in and activity counters
    logic [DS-1:0] mem = '0;
    int lm_cnt = 0;
    int rm_cnt = 0;
    int ready_in_shift = 0;
    int overlap = 0;

    grid_load_sequencer #(
        .DATA_SIZE (DS),
        .WORD_WIDTH(WW),
        .GEN_WIDTH (GW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .begin_load(begin_load),
        .word_in   (word_in),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .start_run (start_run),
        .gen_count (gen_count),
        .pause     (pause),
        .serial_out(serial_out),
        .load_mode (load_mode),
        .run_mode  (run_mode),
        .loaded    (loaded),
        .done      (done),
        .gens_done (gens_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_mode) begin
            mem <= {mem[DS-2:0], serial_out};
            lm_cnt <= lm_cnt + 1;
            if (word_ready) ready_in_shift <= ready_in_shift + 1;
        end
        if (run_mode) rm_cnt <= rm_cnt + 1;
        if (run_mode && load_mode) overlap <= overlap + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(word_ready), 32'd0);
        check({tag, "_serial"}, 32'(serial_out), 32'd0);
        check({tag, "_load"}, 32'(load_mode), 32'd0);
        check({tag, "_run"}, 32'(run_mode), 32'd0);
        check({tag, "_loaded"}, 32'(loaded), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_gens"}, 32'(gens_done), 32'd0);
    endtask

    // begin_load, then two words; ends in LOADED
    task automatic load_grid(input logic [WW-1:0] a, input logic [WW-1:0] b);
        begin_load = 1'b1;
        tick();
        begin_load = 1'b0;
        word_in = a;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        repeat (4) tick();
        word_in = b;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        tick();
    endtask

    int lm_base;
    int rm_base;
    int n;
    int exp_n;
    logic [WW-1:0] first_word;

    initial begin
        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        check_all_zero("idle");

        // Load 1011 then 0111, word_valid held through the first SHIFT
        begin_load = 1'b1;
        tick();
        begin_load = 1'b0;
        check("wait_ready", 32'(word_ready), 32'd1);
        check("wait_load", 32'(load_mode), 32'd0);
        lm_base = lm_cnt;
        word_in = 4'b1011;
        word_valid = 1'b1;
        tick();
        word_in = 4'b0111;
        first_word = 4'b1011;
        for (int i = 0; i < WW; i++) begin
            check($sformatf("shift_load_%0d", i), 32'(load_mode), 32'd1);
            check($sformatf("shift_bit_%0d", i), 32'(serial_out), 32'(first_word[WW-1-i]));
            check($sformatf("shift_ready_%0d", i), 32'(word_ready), 32'd0);
            tick();
        end
        check("rewait_ready", 32'(word_ready), 32'd1);
        check("rewait_load", 32'(load_mode), 32'd0);
        tick();
        word_valid = 1'b0;
        check("w2_load", 32'(load_mode), 32'd1);
        check("w2_bit", 32'(serial_out), 32'd0);
        tick();
        check("loaded", 32'(loaded), 32'd1);
        check("loaded_load", 32'(load_mode), 32'd0);
        check("loaded_serial", 32'(serial_out), 32'd0);
        check("mem_load1", 32'(mem), 32'b10110);
        check("load_cycles", 32'(lm_cnt - lm_base), 32'd5);
        check("ready_in_shift", 32'(ready_in_shift), 32'd0);

        // Run 3 generations, word_valid held high and ignored
        word_valid = 1'b1;
        word_in = 4'b1111;
        lm_base = lm_cnt;
        rm_base = rm_cnt;
        start_run = 1'b1;
        gen_count = 16'd3;
        tick();
        start_run = 1'b0;
        gen_count = 16'd0;
        check("run_first", 32'(run_mode), 32'd1);
        check("run_gens0", 32'(gens_done), 32'd0);
        check("run_loaded", 32'(loaded), 32'd0);
        tick();
        check("run_gens1", 32'(gens_done), 32'd1);
        tick();
        check("run_gens2", 32'(gens_done), 32'd2);
        tick();
        word_valid = 1'b0;
        check("run_done", 32'(done), 32'd1);
        check("run_gens3", 32'(gens_done), 32'd3);
        check("run_mode_off", 32'(run_mode), 32'd0);
        check("run_cycles", 32'(rm_cnt - rm_base), 32'd3);
        check("run_no_load", 32'(lm_cnt - lm_base), 32'd0);
        check("run_ready", 32'(word_ready), 32'd0);
        check("mem_after_run", 32'(mem), 32'b10110);

        // start_run in DONE is ignored
        start_run = 1'b1;
        gen_count = 16'd2;
        tick();
        start_run = 1'b0;
        check("done_ignore_run", 32'(run_mode), 32'd0);
        check("done_hold", 32'(done), 32'd1);
        check("done_gens_hold", 32'(gens_done), 32'd3);

        // Reload, then gen_count = 0
        load_grid(4'b0100, 4'b1000);
        check("loaded2", 32'(loaded), 32'd1);
        check("mem_load2", 32'(mem), 32'b01001);
        check("gens_cleared", 32'(gens_done), 32'd0);
        rm_base = rm_cnt;
        start_run = 1'b1;
        gen_count = 16'd0;
        tick();
        start_run = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        check("zero_run", 32'(run_mode), 32'd0);
        check("zero_gens", 32'(gens_done), 32'd0);
        check("zero_cycles", 32'(rm_cnt - rm_base), 32'd0);

        // Reset after two bits of the first word
        begin_load = 1'b1;
        tick();
        begin_load = 1'b0;
        word_in = 4'b1111;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        reset = 1'b0;
        load_grid(4'b0011, 4'b1000);
        check("loaded3", 32'(loaded), 32'd1);
        check("mem_load3", 32'(mem), 32'b00111);

        // Run 4 generations with pause high for two cycles mid-run
        rm_base = rm_cnt;
        start_run = 1'b1;
        gen_count = 16'd4;
        tick();
        start_run = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            pause = (n == 1 || n == 2);
            tick();
            n++;
        end
        pause = 1'b0;
`ifdef GRID_LOAD_SEQUENCER_PAUSE_EN
        exp_n = 6;
`else
        exp_n = 4;
`endif
        check("pause_latency", 32'(n), 32'(exp_n));
        check("pause_done", 32'(done), 32'd1);
        check("pause_gens", 32'(gens_done), 32'd4);
        check("pause_cycles", 32'(rm_cnt - rm_base), 32'd4);
        check("never_overlap", 32'(overlap), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
